// File: rtl/vector_gather_buffer.sv
// Ping-pong gather buffer: packs a stream of WIDTH-bit elements into DEPTH-element
// vectors using two banks, so one vector can fill while the other waits downstream.
module vector_gather_buffer #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 64,
  parameter int IDX_BITS = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WIDTH-1:0]                s_data,
  input  logic                            s_valid,
  input  logic                            s_last,
  output logic                            s_ready,
  output logic [0:DEPTH-1][WIDTH-1:0]     m_data,
  output logic [IDX_BITS:0]               m_len,
  output logic                            m_valid,
  input  logic                            m_ready
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

  localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(DEPTH - 1);
  localparam logic [IDX_BITS:0]   LEN_ONE  = (IDX_BITS + 1)'(1);

  bank_state_t                    state_q [2];
  bank_state_t                    state_d [2];
  logic [IDX_BITS:0]              len_q   [2];
  logic [IDX_BITS:0]              len_d   [2];
  logic [0:DEPTH-1][WIDTH-1:0]    mem_q   [2];
  logic                           wr_bank_q, wr_bank_d;
  logic                           rd_bank_q, rd_bank_d;
  logic [IDX_BITS-1:0]            idx_q, idx_d;
  logic                           accept, send, close;

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign s_ready = (state_q[wr_bank_q] != FULL);
  assign m_valid = (state_q[rd_bank_q] == FULL);
  assign m_data  = mem_q[rd_bank_q];
  assign m_len   = len_q[rd_bank_q];

  assign accept = s_valid & s_ready;
  assign send   = m_valid & m_ready;
  assign close  = accept & (s_last | (idx_q == IDX_LAST));

  always_comb begin
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    len_d[0]   = len_q[0];
    len_d[1]   = len_q[1];
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    idx_d      = idx_q;

    // Accept and send always target different banks, so both may apply in one cycle.
    if (accept) begin
      if (close) begin
        state_d[wr_bank_q] = FULL;
        len_d[wr_bank_q]   = {1'b0, idx_q} + LEN_ONE;
        wr_bank_d          = ~wr_bank_q;
        idx_d              = '0;
      end else begin
        state_d[wr_bank_q] = FILLING;
        idx_d              = idx_q + IDX_ONE;
      end
    end

    if (send) begin
      state_d[rd_bank_q] = EMPTY;
      len_d[rd_bank_q]   = '0;
      rd_bank_d          = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      len_q[0]   <= len_d[0];
      len_q[1]   <= len_d[1];
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      idx_q      <= idx_d;
    end
  end

  // Banks are cleared on send and reset so a short vector's tail reads as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      if (accept) mem_q[wr_bank_q][idx_q] <= s_data;
      if (send)   mem_q[rd_bank_q]        <= '0;
    end
  end

endmodule
